param_reg_file_sb: RTL and testbench



---
 rtl/param_reg_file_sb_pkg.sv | 18 +
 rtl/param_reg_file_sb_if.sv | 36 +++
 rtl/param_reg_file_sb_reg_scoreboard.sv | 71 +++++++
 rtl/param_reg_file_sb.sv | 83 ++++++++
 tb/tb_param_reg_file_sb.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/param_reg_file_sb_pkg.sv
// Shared defaults and address-width helper for the parameterised register file
// with a per-register pending scoreboard.
package param_reg_file_sb_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 32;

    // Address bits needed to index depth entries; never less than one.
    function automatic int unsigned addr_bits(input int unsigned depth);
        int unsigned n;
        n = 1;
        while ((32'd1 << n) < depth) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/param_reg_file_sb_if.sv
// Bus bundle for param_reg_file_sb: two read ports, one write port and the
// reservation request, plus the scoreboard status outputs.
interface param_reg_file_sb_if
    import param_reg_file_sb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
);

    localparam int unsigned AW = addr_bits(DEPTH);

    logic [AW-1:0]    readAddr1;
    logic [AW-1:0]    readAddr2;
    logic [WIDTH-1:0] readData1;
    logic [WIDTH-1:0] readData2;
    logic             readReady1;
    logic             readReady2;
    logic             writeEn;
    logic [AW-1:0]    writeAddr;
    logic [WIDTH-1:0] writeData;
    logic             rsvEn;
    logic [AW-1:0]    rsvAddr;
    logic             rsvAck;
    logic [AW:0]      pendCount;

    modport master (
        output readAddr1, readAddr2, writeEn, writeAddr, writeData, rsvEn, rsvAddr,
        input  readData1, readData2, readReady1, readReady2, rsvAck, pendCount
    );

    modport slave (
        input  readAddr1, readAddr2, writeEn, writeAddr, writeData, rsvEn, rsvAddr,
        output readData1, readData2, readReady1, readReady2, rsvAck, pendCount
    );

endinterface

// File: rtl/param_reg_file_sb_reg_scoreboard.sv
// Pending-bit scoreboard: tracks outstanding results per register, arbitrates
// reservations and produces registered read-ready flags and the pending count.
module reg_scoreboard #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic          i_rsv_en,
    input  logic [AW-1:0] i_rsv_addr,
    input  logic [AW-1:0] i_rd_addr1,
    input  logic [AW-1:0] i_rd_addr2,
    output logic          o_rsv_ack,
    output logic          o_rd_ready1,
    output logic          o_rd_ready2,
    output logic [AW:0]   o_pend_count
);

    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_next;
    logic             r_ready1;
    logic             r_ready2;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_next;
    logic             w_rsv_ack;
    logic             w_rsv_sets;

    always_comb begin
        // A write landing on the reserved register this cycle frees it in time.
        w_rsv_ack  = i_rsv_en && !rst &&
                     (!r_pend[i_rsv_addr] || (i_wr_en && (i_wr_addr == i_rsv_addr)));
        w_rsv_sets = w_rsv_ack && !(ZERO_REG && (i_rsv_addr == '0));

        // Write clears first so a same-cycle reservation leaves the bit set.
        w_pend_next = r_pend;
        if (i_wr_en) begin
            w_pend_next[i_wr_addr] = 1'b0;
        end
        if (w_rsv_sets) begin
            w_pend_next[i_rsv_addr] = 1'b1;
        end

        w_count_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_count_next = w_count_next + {{AW{1'b0}}, w_pend_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend   <= '0;
            r_ready1 <= 1'b1;
            r_ready2 <= 1'b1;
            r_count  <= '0;
        end else begin
            r_pend   <= w_pend_next;
            r_ready1 <= !w_pend_next[i_rd_addr1];
            r_ready2 <= !w_pend_next[i_rd_addr2];
            r_count  <= w_count_next;
        end
    end

    assign o_rsv_ack    = w_rsv_ack;
    assign o_rd_ready1  = r_ready1;
    assign o_rd_ready2  = r_ready2;
    assign o_pend_count = r_count;

endmodule

// File: rtl/param_reg_file_sb.sv
// Two-read/one-write register file with registered reads, optional write
// bypass, optional hard-wired zero register and a pending-result scoreboard.
module param_reg_file_sb
    import param_reg_file_sb_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input logic                clk,
    input logic                rst,
    param_reg_file_sb_if.slave bus
);

    localparam int unsigned AW = addr_bits(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_rd1_next;
    logic [WIDTH-1:0] w_rd2_next;

    always_comb begin
        w_wr_ok = bus.writeEn && !(ZERO_REG && (bus.writeAddr == '0));

        w_rd1_next = r_mem[bus.readAddr1];
        if (BYPASS && w_wr_ok && (bus.writeAddr == bus.readAddr1)) begin
            w_rd1_next = bus.writeData;
        end
        if (ZERO_REG && (bus.readAddr1 == '0)) begin
            w_rd1_next = '0;
        end

        w_rd2_next = r_mem[bus.readAddr2];
        if (BYPASS && w_wr_ok && (bus.writeAddr == bus.readAddr2)) begin
            w_rd2_next = bus.writeData;
        end
        if (ZERO_REG && (bus.readAddr2 == '0)) begin
            w_rd2_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[bus.writeAddr] <= bus.writeData;
            end
            r_rd1 <= w_rd1_next;
            r_rd2 <= w_rd2_next;
        end
    end

    assign bus.readData1 = r_rd1;
    assign bus.readData2 = r_rd2;

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (bus.writeEn),
        .i_wr_addr    (bus.writeAddr),
        .i_rsv_en     (bus.rsvEn),
        .i_rsv_addr   (bus.rsvAddr),
        .i_rd_addr1   (bus.readAddr1),
        .i_rd_addr2   (bus.readAddr2),
        .o_rsv_ack    (bus.rsvAck),
        .o_rd_ready1  (bus.readReady1),
        .o_rd_ready2  (bus.readReady2),
        .o_pend_count (bus.pendCount)
    );

endmodule

// File: tb/tb_param_reg_file_sb.sv
// Bench for param_reg_file_sb: two instances (zero-reg+bypass, plain) driven in
// lockstep against a behavioural model whose expectations are queued per cycle.
module tb_param_reg_file_sb;

    typedef struct packed {
        bit          rst;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          re;
        logic [4:0]  ra;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } stim_t;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    logic        ack_seen [2];
    logic [31:0] m_mem    [2][32];
    bit          m_pend   [2][32];
    logic [72:0] qa [$];
    logic [72:0] qb [$];

    param_reg_file_sb_if #(.WIDTH(32), .DEPTH(32)) busA ();
    param_reg_file_sb_if #(.WIDTH(32), .DEPTH(32)) busB ();

    param_reg_file_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    param_reg_file_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk(input bit r, input bit we, input logic [4:0] wa,
                                 input logic [31:0] wd, input bit re, input logic [4:0] ra,
                                 input logic [4:0] a1, input logic [4:0] a2);
        stim_t s;
        s.rst = r; s.we = we; s.wa = wa; s.wd = wd;
        s.re = re; s.ra = ra; s.a1 = a1; s.a2 = a2;
        return s;
    endfunction

    function automatic logic [72:0] observed(input int k);
        if (k == 0)
            return {ack_seen[0], busA.readData1, busA.readData2,
                    busA.readReady1, busA.readReady2, busA.pendCount};
        return {ack_seen[1], busB.readData1, busB.readData2,
                busB.readReady1, busB.readReady2, busB.pendCount};
    endfunction

    function automatic logic [72:0] pop_exp(input int k);
        if (k == 0) begin
            if (qa.size() == 0) return 'x;
            return qa.pop_front();
        end
        if (qb.size() == 0) return 'x;
        return qb.pop_front();
    endfunction

    // Drives one cycle, samples the combinational ack mid-cycle, advances the
    // model and queues the expected post-edge view of each instance.
    task automatic step(input stim_t s);
        bit          zr;
        bit          bp;
        bit          wr_ok;
        bit          ack;
        logic [31:0] ed1;
        logic [31:0] ed2;
        logic [5:0]  cnt;
        rst            = s.rst;
        busA.writeEn   = s.we;  busB.writeEn   = s.we;
        busA.writeAddr = s.wa;  busB.writeAddr = s.wa;
        busA.writeData = s.wd;  busB.writeData = s.wd;
        busA.rsvEn     = s.re;  busB.rsvEn     = s.re;
        busA.rsvAddr   = s.ra;  busB.rsvAddr   = s.ra;
        busA.readAddr1 = s.a1;  busB.readAddr1 = s.a1;
        busA.readAddr2 = s.a2;  busB.readAddr2 = s.a2;
        #4;
        ack_seen[0] = busA.rsvAck;
        ack_seen[1] = busB.rsvAck;
        for (int k = 0; k < 2; k++) begin
            zr    = (k == 0);
            bp    = (k == 0);
            wr_ok = s.we && !(zr && s.wa == 5'd0);
            ack   = s.re && !s.rst && (!m_pend[k][s.ra] || (s.we && s.wa == s.ra));
            if (s.rst)                            ed1 = 32'd0;
            else if (zr && s.a1 == 5'd0)          ed1 = 32'd0;
            else if (bp && wr_ok && s.wa == s.a1) ed1 = s.wd;
            else                                  ed1 = m_mem[k][s.a1];
            if (s.rst)                            ed2 = 32'd0;
            else if (zr && s.a2 == 5'd0)          ed2 = 32'd0;
            else if (bp && wr_ok && s.wa == s.a2) ed2 = s.wd;
            else                                  ed2 = m_mem[k][s.a2];
            if (s.rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[k][i]  = 32'd0;
                    m_pend[k][i] = 1'b0;
                end
            end else begin
                if (wr_ok) m_mem[k][s.wa] = s.wd;
                if (s.we) m_pend[k][s.wa] = 1'b0;
                if (ack && !(zr && s.ra == 5'd0)) m_pend[k][s.ra] = 1'b1;
            end
            cnt = 6'd0;
            for (int i = 0; i < 32; i++) cnt = cnt + {5'd0, m_pend[k][i]};
            if (k == 0) qa.push_back({ack, ed1, ed2, !m_pend[k][s.a1], !m_pend[k][s.a2], cnt});
            else        qb.push_back({ack, ed1, ed2, !m_pend[k][s.a1], !m_pend[k][s.a2], cnt});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t       t [2];
        logic [72:0] e;
        t[0] = mk(1'b1, 1'b1, 5'd2, 32'h55, 1'b1, 5'd3, 5'd5, 5'd0);
        t[1] = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd2);
        foreach (t[i]) begin
            step(t[i]);
            for (int k = 0; k < 2; k++) begin
                e = pop_exp(k);
                total++;
                if (observed(k) !== e)
                    $display("FAIL reset[%0d] dut%0d got=%h exp=%h", i, k, observed(k), e);
                else passed++;
            end
        end
    endtask

    task automatic test_bypass();
        stim_t       t [3];
        logic [72:0] e;
        t[0] = mk(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7, 5'd7);
        t[1] = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd6);
        t[2] = mk(1'b0, 1'b1, 5'd6, 32'hA5A5F00D, 1'b0, 5'd0, 5'd7, 5'd6);
        foreach (t[i]) begin
            step(t[i]);
            for (int k = 0; k < 2; k++) begin
                e = pop_exp(k);
                total++;
                if (observed(k) !== e)
                    $display("FAIL bypass[%0d] dut%0d got=%h exp=%h", i, k, observed(k), e);
                else passed++;
            end
        end
    endtask

    task automatic test_zero_reg();
        stim_t       t [4];
        logic [72:0] e;
        t[0] = mk(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
        t[1] = mk(1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd7);
        t[2] = mk(1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 5'd0, 5'd0);
        t[3] = mk(1'b0, 1'b1, 5'd0, 32'h9,    1'b1, 5'd0, 5'd0, 5'd0);
        foreach (t[i]) begin
            step(t[i]);
            for (int k = 0; k < 2; k++) begin
                e = pop_exp(k);
                total++;
                if (observed(k) !== e)
                    $display("FAIL zero_reg[%0d] dut%0d got=%h exp=%h", i, k, observed(k), e);
                else passed++;
            end
        end
    endtask

    task automatic test_reserve();
        stim_t       t [4];
        logic [72:0] e;
        t[0] = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd4);
        t[1] = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd3);
        t[2] = mk(1'b0, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 5'd3, 5'd1);
        t[3] = mk(1'b0, 1'b1, 5'd8, 32'h77, 1'b0, 5'd0, 5'd3, 5'd8);
        foreach (t[i]) begin
            step(t[i]);
            for (int k = 0; k < 2; k++) begin
                e = pop_exp(k);
                total++;
                if (observed(k) !== e)
                    $display("FAIL reserve[%0d] dut%0d got=%h exp=%h", i, k, observed(k), e);
                else passed++;
            end
        end
    endtask

    task automatic test_write_rsv_same();
        stim_t       t [3];
        logic [72:0] e;
        t[0] = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 5'd0);
        t[1] = mk(1'b0, 1'b1, 5'd4, 32'hCAFE0004, 1'b1, 5'd4, 5'd4, 5'd4);
        t[2] = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd3);
        foreach (t[i]) begin
            step(t[i]);
            for (int k = 0; k < 2; k++) begin
                e = pop_exp(k);
                total++;
                if (observed(k) !== e)
                    $display("FAIL write_rsv_same[%0d] dut%0d got=%h exp=%h", i, k, observed(k), e);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t       t [6];
        logic [72:0] e;
        t[0] = mk(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd1, 5'd1, 5'd2);
        t[1] = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd2, 5'd1, 5'd2);
        t[2] = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd2);
        t[3] = mk(1'b1, 1'b1, 5'd2, 32'hBAD, 1'b1, 5'd5, 5'd2, 5'd9);
        t[4] = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd2, 5'd1);
        t[5] = mk(1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd7);
        foreach (t[i]) begin
            step(t[i]);
            for (int k = 0; k < 2; k++) begin
                e = pop_exp(k);
                total++;
                if (observed(k) !== e)
                    $display("FAIL reset_mid[%0d] dut%0d got=%h exp=%h", i, k, observed(k), e);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t       s;
        logic [72:0] e;
        for (int n = 0; n < 200; n++) begin
            s.rst = ($urandom_range(0, 39) == 0);
            s.we  = $urandom_range(0, 1);
            s.wa  = 5'($urandom_range(0, 7));
            s.wd  = $urandom;
            s.re  = $urandom_range(0, 1);
            s.ra  = 5'($urandom_range(0, 7));
            s.a1  = 5'($urandom_range(0, 7));
            s.a2  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : s.wa;
            step(s);
            for (int k = 0; k < 2; k++) begin
                e = pop_exp(k);
                total++;
                if (observed(k) !== e)
                    $display("FAIL back_to_back[%0d] dut%0d got=%h exp=%h", n, k, observed(k), e);
                else passed++;
            end
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[k][i]  = 32'd0;
                m_pend[k][i] = 1'b0;
            end
        end
        test_reset();
        test_bypass();
        test_zero_reg();
        test_reserve();
        test_write_rsv_same();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
